alu_ctrl_md: RTL and testbench
==============================

# alu_ctrl_md

Parametrised successor to the single-cycle ALU control decoder. It decodes `aluop`/`fun7`/`fun3` into a 4-bit ALU control code covering the full RV32I ALU set, with a defined default so no latch is inferred. It adds an iterative RV-M multiply/divide sequencer with a stall handshake back to the core. It sits between the main control unit and the ALU/writeback mux in the single-cycle processor.

## Interface
- `XLEN`, 32: operand/result width; must be ≥ 8 and even.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid` in 1: an instruction is presented this cycle.
- `kill` in 1: abort any in-flight M operation (flush).
- `aluop` in 2: 00 load/store add, 01 branch sub, 10 R-type, 11 I-type.
- `fun7` in 7: full funct7 field.
- `fun3` in 3: funct3 field.
- `op_a` in XLEN: rs1 value.
- `op_b` in XLEN: rs2 value.
- `control_out` out 4: ALU control code (combinational).
- `md_sel` out 1: writeback takes `md_result` instead of the ALU output.
- `md_result` out XLEN: M-extension result; valid when `md_done` = 1.
- `md_done` out 1: one-cycle pulse when the result is valid.
- `stall` out 1: freeze PC/regfile write this cycle.

## Operation
- Control codes: AND 0000, OR 0001, ADD 0010, SLL 0011, XOR 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, MD 1111.
- aluop 00 → ADD; aluop 01 → SUB.
- aluop 10, fun7 0000000 → fun3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
- aluop 10, fun7 0100000 → fun3 000 SUB, fun3 101 SRA.
- aluop 10, fun7 0000001 → MD.
- aluop 11 → as R-type with fun7 ignored, except fun3 101, where fun7 bit 5 selects SRA vs SRL; SUB is never produced.
- Any other combination → ADD.
- MD ops by fun3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Signed operands are converted to magnitude at start. The result is negated at finish as RV-M requires.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Multiply: shift-add, one bit per cycle, 2·XLEN-bit accumulator. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide: restoring, one quotient bit per cycle.
- Special cases resolved in IDLE with no BUSY phase:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `op_a`.
  - Signed overflow (DIV/REM of −2^(XLEN−1) by −1): DIV → `op_a`; REM → 0.
- FSM states:
  - IDLE: if `valid` && code = MD && !`kill`, latch operands and fun3. Go to DONE on a special case, else to BUSY with count = 0.
  - BUSY: iterate; count++. Go to DONE when count = XLEN−1. `kill` → IDLE.
  - DONE: present the result, assert `md_done`. Go to IDLE unconditionally.
- `md_sel` = 1 whenever the decoded code is MD.

## Timing
- Reset values: state IDLE, count 0, `md_result` 0, `md_done` 0, `stall` 0. Internal accumulators are 0.
- `control_out` and `md_sel` are purely combinational from the inputs.
- `stall` = 1 in IDLE when an MD op is presented and not killed, and throughout BUSY. `stall` = 0 in DONE.
- Normal latency: start in cycle 0, BUSY in cycles 1..XLEN, DONE in cycle XLEN+1. Stall is high for XLEN+1 cycles.
- Special-case latency: stall is high 1 cycle; DONE is the next cycle.
- The core holds `aluop`/`fun*`/`op_*` stable while `stall` = 1. The block ignores input changes after the start cycle because operands are latched.
- DONE does not re-trigger on the still-presented MD instruction. IDLE is entered only after DONE, and the core advances the PC in the DONE cycle.
- `kill` in BUSY → IDLE next cycle, with no `md_done`. `kill` in DONE has no effect; the pulse still occurs.
- `rst_n` low at any point → immediate return to reset values. A new op starts cleanly after release.

## Structure
- Package `alu_pkg`:
  - control-code localparams
  - aluop encodings
  - funct7 constants (0000000, 0100000, 0000001)
  - MD fun3 codes
  - FSM state encoding (IDLE/BUSY/DONE)
- Sub-module `md_iter`: XLEN-parametrised shift-add/restoring datapath, plus sign fix-up, stepped by the FSM.
- Top: decoder, FSM, counter.

## Test plan
- R-type sweep, XLEN=32: aluop 10, fun7 0100000, fun3 101 → `control_out` 0111. Same with fun3 000 → 0110. aluop 11, fun7 0100000, fun3 000 → 0010. aluop 10, fun7 1111111 → 0010.
- MUL: a = 7, b = −3 (fun3 000) → `stall` high 33 cycles, then `md_done` with `md_result` 0xFFFFFFEB. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV/REM: −7 ÷ 2 → quotient 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100 ÷ 7 → 14; REMU → 2.
- Special cases: DIV 5 ÷ 0 → 0xFFFFFFFF after 1 stall cycle. REM 0x80000000 ÷ −1 → 0. DIV of the same operands → 0x80000000.
- Abort: assert `kill` at BUSY cycle 10 → IDLE next cycle, no `md_done`. A following DIVU 9 ÷ 3 → 3.
- Reset mid-op: drop `rst_n` during BUSY → `stall` 0, `md_done` 0, `md_result` 0 immediately. After release, MUL 6 × 7 → 42.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU control decoder and the RV-M sequencer.
// Contents: ALU control codes, aluop encodings, funct7 constants, M-extension
// funct3 codes, sequencer state encoding and the base R/I-type funct3 decode.
package alu_pkg;

    localparam logic [3:0] CtrlAnd  = 4'b0000;
    localparam logic [3:0] CtrlOr   = 4'b0001;
    localparam logic [3:0] CtrlAdd  = 4'b0010;
    localparam logic [3:0] CtrlSll  = 4'b0011;
    localparam logic [3:0] CtrlXor  = 4'b0100;
    localparam logic [3:0] CtrlSrl  = 4'b0101;
    localparam logic [3:0] CtrlSub  = 4'b0110;
    localparam logic [3:0] CtrlSra  = 4'b0111;
    localparam logic [3:0] CtrlSlt  = 4'b1000;
    localparam logic [3:0] CtrlSltu = 4'b1001;
    localparam logic [3:0] CtrlMd   = 4'b1111;

    localparam logic [1:0] AluOpMem    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpRtype  = 2'b10;
    localparam logic [1:0] AluOpItype  = 2'b11;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mul  = 7'b0000001;

    localparam logic [2:0] MdMul    = 3'b000;
    localparam logic [2:0] MdMulh   = 3'b001;
    localparam logic [2:0] MdMulhsu = 3'b010;
    localparam logic [2:0] MdMulhu  = 3'b011;
    localparam logic [2:0] MdDiv    = 3'b100;
    localparam logic [2:0] MdDivu   = 3'b101;
    localparam logic [2:0] MdRem    = 3'b110;
    localparam logic [2:0] MdRemu   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } md_state_e;

    // funct3 decode shared by R-type (funct7 = 0) and I-type.
    function automatic logic [3:0] base_ctrl(input logic [2:0] fun3);
        logic [3:0] code;
        case (fun3)
            3'b000:  code = CtrlAdd;
            3'b001:  code = CtrlSll;
            3'b010:  code = CtrlSlt;
            3'b011:  code = CtrlSltu;
            3'b100:  code = CtrlXor;
            3'b101:  code = CtrlSrl;
            3'b110:  code = CtrlOr;
            default: code = CtrlAnd;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_ctrl_md_iter.sv
// md_iter: iterative RV-M datapath. Shift-add multiply and restoring divide
// share one 2*XLEN accumulator; one bit is processed per step.
// Ports: clk, rst_n; start (latch operands/fun3), step (advance one bit);
// fun3, op_a, op_b (raw instruction operands); special/special_result
// (divide-by-zero and signed-overflow outcome, combinational from inputs);
// step_result (sign-corrected result as it will be after the current step).
module md_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            special,
    output logic [XLEN-1:0] special_result,
    output logic [XLEN-1:0] step_result
);

    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        fun3_q, fun3_d;
    logic              neg_q, neg_d;

    logic              is_div, a_signed, b_signed, sign_a, sign_b, neg_start;
    logic              div_zero, overflow;
    logic [XLEN-1:0]   mag_a, mag_b, hi, lo, val;
    logic [XLEN:0]     sum, rem_sh, diff;
    logic              ge;

    // Operand conditioning at start.
    always_comb begin
        is_div    = fun3[2];
        a_signed  = is_div ? !fun3[0] : (fun3 == MdMulh || fun3 == MdMulhsu);
        b_signed  = is_div ? !fun3[0] : (fun3 == MdMulh);
        sign_a    = a_signed & op_a[XLEN-1];
        sign_b    = b_signed & op_b[XLEN-1];
        mag_a     = sign_a ? -op_a : op_a;
        mag_b     = sign_b ? -op_b : op_b;
        // Remainder follows the dividend; everything else is sign(a)^sign(b).
        neg_start = (is_div && fun3[1]) ? sign_a : (sign_a ^ sign_b);
        div_zero  = (op_b == '0);
        overflow  = !fun3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special   = is_div && (div_zero || overflow);
        if (div_zero) begin
            special_result = fun3[1] ? op_a : '1;
        end else begin
            special_result = fun3[1] ? '0 : op_a;
        end
    end

    // One iteration. Multiply: {carry,hi,lo} >> 1 after conditional add.
    // Divide: shift {hi,lo} left, subtract divisor from hi when it fits.
    always_comb begin
        hi       = acc_q[2*XLEN-1:XLEN];
        lo       = acc_q[XLEN-1:0];
        sum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {hi, lo[XLEN-1]};
        diff     = rem_sh - {1'b0, opnd_q};
        ge       = (rem_sh >= {1'b0, opnd_q});
        if (fun3_q[2]) begin
            acc_step = {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), lo[XLEN-2:0], ge};
        end else begin
            acc_step = {sum, lo[XLEN-1:1]};
        end

        prod = neg_q ? -acc_step : acc_step;
        val  = fun3_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        if (fun3_q[2]) begin
            step_result = neg_q ? -val : val;
        end else if (fun3_q[1:0] == 2'b00) begin
            step_result = prod[XLEN-1:0];
        end else begin
            step_result = prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        fun3_d = fun3_q;
        neg_d  = neg_q;
        if (start) begin
            // Divide: dividend sits in lo, divisor in opnd.
            // Multiply: multiplier sits in lo, multiplicand in opnd.
            acc_d  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            opnd_d = is_div ? mag_b : mag_a;
            fun3_d = fun3;
            neg_d  = neg_start;
        end else if (step) begin
            acc_d = acc_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            fun3_q <= '0;
            neg_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            fun3_q <= fun3_d;
            neg_q  <= neg_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: ALU control decoder with an iterative RV-M sequencer.
// Ports: clk, rst_n (async, active low); valid, kill; aluop, fun7, fun3;
// op_a, op_b (rs1/rs2); control_out (combinational ALU code); md_sel
// (writeback takes md_result); md_result/md_done (one-cycle result pulse);
// stall (freeze PC and regfile write).
module alu_ctrl_md
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid,
    input  logic            kill,
    input  logic [1:0]      aluop,
    input  logic [6:0]      fun7,
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      control_out,
    output logic            md_sel,
    output logic [XLEN-1:0] md_result,
    output logic            md_done,
    output logic            stall
);

    localparam int unsigned    CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

    md_state_e         state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              start, step, special;
    logic [XLEN-1:0]   special_result, step_result;

    always_comb begin
        control_out = CtrlAdd;
        unique case (aluop)
            AluOpMem:    control_out = CtrlAdd;
            AluOpBranch: control_out = CtrlSub;
            AluOpRtype: begin
                if (fun7 == F7Base) begin
                    control_out = base_ctrl(fun3);
                end else if (fun7 == F7Alt) begin
                    if (fun3 == 3'b000) begin
                        control_out = CtrlSub;
                    end else if (fun3 == 3'b101) begin
                        control_out = CtrlSra;
                    end
                end else if (fun7 == F7Mul) begin
                    control_out = CtrlMd;
                end
            end
            AluOpItype: begin
                // Immediate forms: only the shift-right pair looks at funct7.
                if (fun3 == 3'b101) begin
                    control_out = fun7[5] ? CtrlSra : CtrlSrl;
                end else begin
                    control_out = base_ctrl(fun3);
                end
            end
            default: control_out = CtrlAdd;
        endcase
        md_sel = (control_out == CtrlMd);
    end

    md_iter #(
        .XLEN (XLEN)
    ) u_md_iter (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .step           (step),
        .fun3           (fun3),
        .op_a           (op_a),
        .op_b           (op_b),
        .special        (special),
        .special_result (special_result),
        .step_result    (step_result)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        start    = 1'b0;
        step     = 1'b0;
        stall    = 1'b0;
        md_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid && md_sel && !kill) begin
                    stall = 1'b1;
                    start = 1'b1;
                    if (special) begin
                        result_d = special_result;
                        state_d  = StDone;
                    end else begin
                        count_d = '0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (kill) begin
                    count_d = '0;
                    state_d = StIdle;
                end else begin
                    step    = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == CntLast) begin
                        count_d  = '0;
                        result_d = step_result;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                // Core advances the PC now; no re-trigger on the held instruction.
                md_done = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    assign md_result = result_q;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// tb_alu_ctrl_md: self-checking bench for alu_ctrl_md (XLEN = 32).
// A latency/arithmetic model runs beside the DUT and is compared every cycle;
// directed operations additionally check hand-computed literal results.
module tb_alu_ctrl_md;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid = 1'b0;
    logic            kill = 1'b0;
    logic [1:0]      aluop = 2'b00;
    logic [6:0]      fun7 = 7'd0;
    logic [2:0]      fun3 = 3'd0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic [3:0]      control_out;
    logic            md_sel;
    logic [XLEN-1:0] md_result;
    logic            md_done;
    logic            stall;

    int checks = 0;
    int errors = 0;

    alu_ctrl_md #(
        .XLEN (XLEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (valid),
        .kill        (kill),
        .aluop       (aluop),
        .fun7        (fun7),
        .fun3        (fun3),
        .op_a        (op_a),
        .op_b        (op_b),
        .control_out (control_out),
        .md_sel      (md_sel),
        .md_result   (md_result),
        .md_done     (md_done),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected ALU code, straight from the decode rules.
    function automatic logic [3:0] exp_ctrl(input logic [1:0] op, input logic [6:0] f7,
                                            input logic [2:0] f3);
        logic [3:0] tbl [8];
        tbl = '{4'h2, 4'h3, 4'h8, 4'h9, 4'h4, 4'h5, 4'h1, 4'h0};
        if (op == 2'd0) return 4'h2;
        if (op == 2'd1) return 4'h6;
        if (op == 2'd3) return (f3 == 3'd5) ? (f7[5] ? 4'h7 : 4'h5) : tbl[f3];
        if (f7 == 7'h00) return tbl[f3];
        if (f7 == 7'h01) return 4'hF;
        if (f7 == 7'h20 && f3 == 3'd0) return 4'h6;
        if (f7 == 7'h20 && f3 == 3'd5) return 4'h7;
        return 4'h2;
    endfunction

    function automatic bit md_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // RV-M result using 64-bit arithmetic.
    function automatic logic [31:0] md_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, ub, q;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb; return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb; return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Model: cycles of BUSY left, DONE pending, expected result.
    int          m_busy = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy > 0) begin
            if (kill) begin
                m_busy <= 0;
            end else if (m_busy == 1) begin
                m_busy <= 0;
                m_done <= 1'b1;
            end else begin
                m_busy <= m_busy - 1;
            end
        end else if (valid && exp_ctrl(aluop, fun7, fun3) == 4'hF && !kill) begin
            m_res <= md_model(fun3, op_a, op_b);
            if (md_special(fun3, op_a, op_b)) m_done <= 1'b1;
            else m_busy <= XLEN;
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (rst_n) begin
            e = exp_ctrl(aluop, fun7, fun3);
            chk("control_out", {28'd0, control_out}, {28'd0, e});
            chk("md_sel", {31'd0, md_sel}, {31'd0, (e == 4'hF)});
            if (m_done) begin
                chk("stall_done", {31'd0, stall}, 32'd0);
                chk("md_done", {31'd0, md_done}, 32'd1);
                chk("md_result", md_result, m_res);
            end else if (m_busy > 0) begin
                chk("stall_busy", {31'd0, stall}, 32'd1);
                chk("md_done_busy", {31'd0, md_done}, 32'd0);
            end else begin
                chk("stall_idle", {31'd0, stall}, {31'd0, (valid && e == 4'hF && !kill)});
                chk("md_done_idle", {31'd0, md_done}, 32'd0);
            end
        end
    end

    task automatic idle_inputs();
        valid = 1'b0; kill = 1'b0; aluop = 2'b00; fun7 = 7'd0; fun3 = 3'd0;
    endtask

    // Present an M instruction, hold it until md_done, check result and stall length.
    task automatic do_md(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
        int          stalls;
        bit          got;
        logic [31:0] res;
        @(posedge clk); #1;
        valid = 1'b1; aluop = 2'b10; fun7 = 7'h01; fun3 = f; op_a = a; op_b = b;
        stalls = 0; got = 1'b0; res = '0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (md_done) begin
                got = 1'b1;
                res = md_result;
            end else if (stall) begin
                stalls++;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
        chk({name, "_result"}, res, exp);
        chk({name, "_stall_cycles"}, stalls, exp_stall);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] code;
    } dec_vec_t;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stl;
    } md_vec_t;

    initial begin
        dec_vec_t dv [4];
        md_vec_t  mv [13];
        int       pulses;

        dv = '{'{2'b10, 7'h20, 3'd5, 4'b0111}, '{2'b10, 7'h20, 3'd0, 4'b0110},
               '{2'b11, 7'h20, 3'd0, 4'b0010}, '{2'b10, 7'h7F, 3'd0, 4'b0010}};
        mv = '{
            '{"mul",       3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33},
            '{"mulhu",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
            '{"mulh",      3'd1, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 33},
            '{"mulhsu",    3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33},
            '{"div",       3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33},
            '{"rem",       3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33},
            '{"divu",      3'd5, 32'd100,        32'd7,         32'd14,        33},
            '{"remu",      3'd7, 32'd100,        32'd7,         32'd2,         33},
            '{"div_by0",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1},
            '{"remu_by0",  3'd7, 32'd77,         32'd0,         32'd77,        1},
            '{"rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1},
            '{"div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{"divu_big",  3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33}};

        // Reset state.
        #3;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_md_done", {31'd0, md_done}, 32'd0);
        chk("rst_md_result", md_result, 32'd0);
        chk("rst_control_out", {28'd0, control_out}, 32'h2);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Hand-computed decode vectors.
        foreach (dv[i]) begin
            @(posedge clk); #1;
            aluop = dv[i].op; fun7 = dv[i].f7; fun3 = dv[i].f3;
            @(negedge clk);
            chk("dec_literal", {28'd0, control_out}, {28'd0, dv[i].code});
        end

        // Decode sweep, no instruction valid; the compare process checks each cycle.
        for (int op = 0; op < 4; op++) begin
            for (int k = 0; k < 5; k++) begin
                for (int f = 0; f < 8; f++) begin
                    logic [6:0] f7s [5];
                    f7s = '{7'h00, 7'h20, 7'h01, 7'h7F, 7'h5A};
                    @(posedge clk); #1;
                    aluop = 2'(op); fun7 = f7s[k]; fun3 = 3'(f);
                end
            end
        end
        @(posedge clk); #1;
        idle_inputs();

        foreach (mv[i]) begin
            do_md(mv[i].name, mv[i].f, mv[i].a, mv[i].b, mv[i].exp, mv[i].stl);
        end

        // Abort in BUSY cycle 10.
        @(posedge clk); #1;
        valid = 1'b1; aluop = 2'b10; fun7 = 7'h01; fun3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        pulses = 0;
        @(negedge clk);
        chk("kill_stall_next", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (md_done) pulses++;
            @(negedge clk);
        end
        chk("kill_no_done", pulses, 0);
        do_md("divu_after_kill", 3'd5, 32'd9, 32'd3, 32'd3, 33);

        // Reset mid-operation.
        @(posedge clk); #1;
        valid = 1'b1; aluop = 2'b10; fun7 = 7'h01; fun3 = 3'd0; op_a = 32'd6; op_b = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_md_done", {31'd0, md_done}, 32'd0);
        chk("midrst_md_result", md_result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_md("mul_after_rst", 3'd0, 32'd6, 32'd7, 32'd42, 33);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
